// File: rtl/tomasulo_rob.sv
// rtl/tomasulo_rob.sv - parametrised in-order-retire reorder buffer with CDB capture and flush
// Optional ROB_CDB_BYPASS_EN: forward same-cycle CDB results onto the operand read ports.
module tomasulo_rob #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 16,
  parameter int REG_W     = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic                        clk1,
  input  logic                        rst_n,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [REG_W-1:0]            alloc_dest,
  input  logic                        alloc_is_br,
  input  logic                        alloc_is_st,
  output logic [TAG_W-1:0]            alloc_tag,
  input  logic [CDB_PORTS-1:0]        cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_data,
  input  logic [CDB_PORTS-1:0]        cdb_mispred,
  input  logic [TAG_W-1:0]            rd0_tag,
  input  logic [TAG_W-1:0]            rd1_tag,
  output logic                        rd0_ready,
  output logic                        rd1_ready,
  output logic [DATA_W-1:0]           rd0_data,
  output logic [DATA_W-1:0]           rd1_data,
  output logic                        commit_valid,
  input  logic                        commit_ready,
  output logic [TAG_W-1:0]            commit_tag,
  output logic [REG_W-1:0]            commit_dest,
  output logic [DATA_W-1:0]           commit_data,
  output logic                        commit_is_st,
  output logic                        flush,
  output logic [TAG_W:0]              count
);

  logic [DEPTH-1:0]  busy, done, mispred, is_br, is_st;
  logic [REG_W-1:0]  dest [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic [TAG_W-1:0]  head, tail;
  logic [TAG_W:0]    count_q;
  logic              flush_q;

  logic              alloc_fire, commit_fire, do_flush;
  logic [DEPTH-1:0]  cdb_hit, cdb_misp, cdb_we;
  logic [DATA_W-1:0] cdb_wdata [DEPTH];

  assign alloc_ready  = (count_q < (TAG_W+1)'(DEPTH)) & ~flush_q;
  assign alloc_fire   = alloc_valid & alloc_ready;
  assign alloc_tag    = tail;
  assign commit_valid = busy[head] & done[head];
  assign commit_fire  = commit_valid & commit_ready;
  assign do_flush     = commit_fire & mispred[head];
  assign commit_tag   = head;
  assign commit_dest  = dest[head];
  assign commit_data  = data[head];
  assign commit_is_st = is_st[head];
  assign flush        = flush_q;
  assign count        = count_q;

  // Per-entry CDB match; scanning ports high to low lets the lowest index win.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cdb_hit[i]   = 1'b0;
      cdb_misp[i]  = 1'b0;
      cdb_wdata[i] = '0;
      for (int p = CDB_PORTS-1; p >= 0; p--) begin
        if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == TAG_W'(i))) begin
          cdb_hit[i]   = 1'b1;
          cdb_misp[i]  = cdb_mispred[p];
          cdb_wdata[i] = cdb_data[p*DATA_W +: DATA_W];
        end
      end
      cdb_we[i] = cdb_hit[i] & busy[i] & ~done[i] & ~flush_q;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      done    <= '0;
      mispred <= '0;
      is_br   <= '0;
      is_st   <= '0;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
    end else begin
      flush_q <= do_flush;
      if (do_flush) begin
        busy    <= '0;
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cdb_we[i]) begin
            done[i]    <= 1'b1;
            mispred[i] <= cdb_misp[i] & is_br[i];
          end
        end
        if (commit_fire) begin
          busy[head] <= 1'b0;
          head       <= head + 1'b1;
        end
        // The tail entry is never busy, so a CDB hit on it cannot collide here.
        if (alloc_fire) begin
          busy[tail]    <= 1'b1;
          done[tail]    <= 1'b0;
          mispred[tail] <= 1'b0;
          is_br[tail]   <= alloc_is_br;
          is_st[tail]   <= alloc_is_st;
          tail          <= tail + 1'b1;
        end
        count_q <= count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);
      end
    end
  end

  always_ff @(posedge clk1) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_we[i]) data[i] <= cdb_wdata[i];
    end
    if (alloc_fire) dest[tail] <= alloc_dest;
  end

  logic [TAG_W-1:0]  rd_tag [2];
  logic              rd_rdy [2];
  logic [DATA_W-1:0] rd_dat [2];

  assign rd_tag[0] = rd0_tag;
  assign rd_tag[1] = rd1_tag;

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      rd_rdy[r] = busy[rd_tag[r]] & done[rd_tag[r]];
      rd_dat[r] = data[rd_tag[r]];
`ifdef ROB_CDB_BYPASS_EN
      if (!rd_rdy[r] && busy[rd_tag[r]] && cdb_hit[rd_tag[r]] && !flush_q) begin
        rd_rdy[r] = 1'b1;
        rd_dat[r] = cdb_wdata[rd_tag[r]];
      end
`endif
    end
  end

  assign rd0_ready = rd_rdy[0];
  assign rd1_ready = rd_rdy[1];
  assign rd0_data  = rd_dat[0];
  assign rd1_data  = rd_dat[1];

endmodule
